vreg_addr_seq: RTL
==================

VREG_ADDR_SEQ -- requirements
Module: vreg_addr_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: vector register address width (32 registers).
REQ-002 SHALL have parameter NUM_CH, default 3: independent address channels (ch0=vs1, ch1=vs2, ch2=vd).
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: command present.
REQ-006 SHALL have port in_ready, output, 1: command accepted when in_valid&in_ready.
REQ-007 SHALL have port vlmul, input, 3: LMUL code; 0..3 = group of 1/2/4/8 regs; 4..7 = group of 1.
REQ-008 SHALL have port widen, input, 1: widening operation.
REQ-009 SHALL have port rep_mask, input, NUM_CH: per-channel repeat (narrow operand) flag, used only when widen=1.
REQ-010 SHALL have port base_addr, input, NUM_CH*ADDR_WIDTH: per-channel group base address, ch0 in LSBs.
REQ-011 SHALL have port flush, input, 1: synchronous abort.
REQ-012 SHALL have port out_valid, output, 1: beat valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts beat.
REQ-014 SHALL have port addr_out, output, NUM_CH*ADDR_WIDTH: per-channel register address of current beat.
REQ-015 SHALL have ports out_first and out_last, output, 1 each: first / last beat of a command.
REQ-016 SHALL have port err, output, 1: one-cycle pulse on rejected command.
REQ-017 SHALL have port idle, output, 1: high when IDLE and no beat pending.

Function
REQ-018 SHALL implement states IDLE and BUSY; IDLE->BUSY on accepted legal command; BUSY->IDLE on last beat handshake without new accept, or on flush.
REQ-019 SHALL compute G = 1<<vlmul for vlmul<4, else 1; beat count N = G when widen=0, 2*G when widen=1.
REQ-020 SHALL reject widen=1 with vlmul=3 (N=16 exceeds 8-reg group): accept (in_ready high), pulse err next cycle, emit no beats, stay IDLE.
REQ-021 SHALL present first beat registered: command accepted at cycle T -> out_valid=1, out_first=1 at T+1.
REQ-022 SHALL, per beat index k (0..N-1), drive channel c address = base_c + k, except widen=1 and rep_mask[c]=1 -> base_c + (k>>1).
REQ-023 SHALL compute addresses modulo 2^ADDR_WIDTH (wrap 31->0).
REQ-024 SHALL hold addr_out, out_first, out_last, out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL advance k only on out_valid&out_ready; out_last=1 exactly when k=N-1.
REQ-026 SHALL assert in_ready when IDLE, or when BUSY and current beat is last and out_ready=1 (zero-bubble back-to-back); in_ready=0 when flush=1.
REQ-027 SHALL, on flush, drop out_valid next cycle, discard remaining beats, return IDLE; flush and in_valid same cycle -> command not accepted.
REQ-028 SHALL deassert idle whenever in_valid&in_ready, state BUSY, or err pending.

Reset
REQ-029 SHALL on rst force IDLE, out_valid=0, out_first=0, out_last=0, err=0, addr_out=0, beat counter=0, idle=1, immediately and independent of clk.
REQ-030 SHALL abandon any in-flight command on rst mid-operation; no beats emitted after rst deasserts until a new accept.

Configuration
REQ-031 SHALL compile a group-alignment check when macro VREG_ADDR_SEQ_ALIGN_CHECK_EN is defined: command rejected as REQ-020 if any base_c not multiple of its group size (G, or 2*G for non-rep channels when widen=1).
REQ-032 SHALL, without VREG_ADDR_SEQ_ALIGN_CHECK_EN, accept misaligned bases and generate addresses per REQ-022 with wrap.

Verification
REQ-033 SHALL cover: vlmul=2, widen=0, bases {8,16,24}, out_ready=1 -> 4 beats {8,16,24},{9,17,25},{10,18,26},{11,19,27}; first on beat0, last on beat3.
REQ-034 SHALL cover: vlmul=1, widen=1, rep_mask=3'b011, bases {2,4,8} -> 4 beats ch0 2,2,3,3; ch1 4,4,5,5; ch2 8,9,10,11.
REQ-035 SHALL cover: out_ready low 3 cycles mid-command -> addr_out/out_last unchanged during stall, total beats still N.
REQ-036 SHALL cover: two commands back-to-back (vlmul=0 then vlmul=1) -> in_ready high on last beat, no idle cycle between beat streams.
REQ-037 SHALL cover: widen=1, vlmul=3 -> err pulse 1 cycle, out_valid stays 0; base 30 vlmul=2 with macro undefined -> 30,31,0,1; with macro defined -> err.
REQ-038 SHALL cover: flush at beat 2 of 8 and rst asserted at beat 1 -> out_valid 0 next cycle / immediately, idle=1, no residual beats.

Source files
------------

// File: rtl/vreg_addr_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vreg_addr_seq_if                                                 |
// | Brief   : Command-in / beat-out bus of the vector register address seq.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface vreg_addr_seq_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_CH     = 3
);
  logic                         in_valid;
  logic                         in_ready;
  logic [2:0]                   vlmul;
  logic                         widen;
  logic [NUM_CH-1:0]            rep_mask;
  logic [NUM_CH*ADDR_WIDTH-1:0] base_addr;
  logic                         flush;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr_out;
  logic                         out_first;
  logic                         out_last;
  logic                         err;
  logic                         idle;

  modport master (
    output in_valid, vlmul, widen, rep_mask, base_addr, flush, out_ready,
    input  in_ready, out_valid, addr_out, out_first, out_last, err, idle
  );

  modport slave (
    input  in_valid, vlmul, widen, rep_mask, base_addr, flush, out_ready,
    output in_ready, out_valid, addr_out, out_first, out_last, err, idle
  );
endinterface
`default_nettype wire

// File: rtl/vreg_addr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vreg_addr_seq                                                    |
// | Brief   : Expands one LMUL/widen command into per-beat register addresses |
// |           for NUM_CH channels. Define VREG_ADDR_SEQ_ALIGN_CHECK_EN to     |
// |           reject commands whose bases are not group-aligned.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vreg_addr_seq #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_CH     = 3
) (
  input  logic           clk,
  input  logic           rst,
  vreg_addr_seq_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                       r_state,    w_state_nxt;
  logic [3:0]                   r_k,        w_k_nxt;
  logic [3:0]                   r_last_idx, w_last_idx_nxt;
  logic                         r_widen,    w_widen_nxt;
  logic [NUM_CH-1:0]            r_rep,      w_rep_nxt;
  logic [NUM_CH*ADDR_WIDTH-1:0] r_base,     w_base_nxt;
  logic                         r_err,      w_err_nxt;

  logic [3:0] w_grp;
  logic [3:0] w_cmd_last;
  logic       w_align_ok;
  logic       w_legal;
  logic       w_accept;
  logic       w_busy;
  logic       w_last;
  logic       w_hs;

  assign w_grp      = bus.vlmul[2] ? 4'd1 : (4'd1 << bus.vlmul[1:0]);
  assign w_cmd_last = bus.widen ? ((w_grp << 1) - 4'd1) : (w_grp - 4'd1);

`ifdef VREG_ADDR_SEQ_ALIGN_CHECK_EN
  localparam int MW = (ADDR_WIDTH > 5) ? ADDR_WIDTH : 5;
  logic [NUM_CH-1:0] w_misalign;

  // Full-rate (non-repeated) channels of a widening op span a double group.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_align
    logic [4:0]    w_size_m1;
    logic [MW-1:0] w_base_ext;
    assign w_size_m1  = (bus.widen && !bus.rep_mask[c]) ? ({w_grp, 1'b0} - 5'd1)
                                                         : ({1'b0, w_grp} - 5'd1);
    assign w_base_ext = MW'(bus.base_addr[c*ADDR_WIDTH +: ADDR_WIDTH]);
    assign w_misalign[c] = |(w_base_ext & MW'(w_size_m1));
  end
  assign w_align_ok = ~|w_misalign;
`else
  assign w_align_ok = 1'b1;
`endif

  assign w_busy   = (r_state == S_BUSY);
  assign w_last   = w_busy && (r_k == r_last_idx);
  assign w_hs     = w_busy && bus.out_ready;
  assign w_legal  = !(bus.widen && (bus.vlmul == 3'd3)) && w_align_ok;

  // A new command may slip in on the same edge the last beat is taken.
  assign bus.in_ready = !rst && !bus.flush && (!w_busy || (w_last && bus.out_ready));
  assign w_accept     = bus.in_valid && bus.in_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_k_nxt        = r_k;
    w_last_idx_nxt = r_last_idx;
    w_widen_nxt    = r_widen;
    w_rep_nxt      = r_rep;
    w_base_nxt     = r_base;
    w_err_nxt      = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
      w_k_nxt     = 4'd0;
    end else if (w_accept && w_legal) begin
      w_state_nxt    = S_BUSY;
      w_k_nxt        = 4'd0;
      w_last_idx_nxt = w_cmd_last;
      w_widen_nxt    = bus.widen;
      w_rep_nxt      = bus.rep_mask;
      w_base_nxt     = bus.base_addr;
    end else begin
      w_err_nxt = w_accept;
      if (w_hs) begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_k_nxt     = 4'd0;
        end else begin
          w_k_nxt = r_k + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_k        <= 4'd0;
      r_last_idx <= 4'd0;
      r_widen    <= 1'b0;
      r_rep      <= '0;
      r_base     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_widen    <= w_widen_nxt;
      r_rep      <= w_rep_nxt;
      r_base     <= w_base_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Repeated (narrow) operands advance one register every two beats.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_addr
    logic [3:0] w_off;
    assign w_off = (r_widen && r_rep[c]) ? (r_k >> 1) : r_k;
    assign bus.addr_out[c*ADDR_WIDTH +: ADDR_WIDTH] =
      r_base[c*ADDR_WIDTH +: ADDR_WIDTH] + ADDR_WIDTH'(w_off);
  end

  assign bus.out_valid = w_busy;
  assign bus.out_first = w_busy && (r_k == 4'd0);
  assign bus.out_last  = w_last;
  assign bus.err       = r_err;
  assign bus.idle      = !w_busy && !w_accept && !r_err;

endmodule
`default_nettype wire
